// File: rtl/fsml_frame_tx.sv
// fsml_frame_tx: serial framer sending each data bit as a "1, 0, bit" frame,
// with optional idle gaps between frames and a one-cycle Done after each word.
`default_nettype none

module fsml_frame_tx #(
    parameter int WIDTH     = 8,
    parameter int GAP       = 0,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    output logic             dout,
    output logic             busy,
    output logic             done
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_SYNC = 3'd1;
    localparam logic [2:0] S_FILL = 3'd2;
    localparam logic [2:0] S_DATA = 3'd3;
    localparam logic [2:0] S_GAP  = 3'd4;

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
    localparam logic [CW-1:0] C_LAST_BIT = CW'(WIDTH - 1);
    localparam logic [GW-1:0] C_GAP_LOAD = (GAP > 0) ? GW'(GAP - 1) : '0;

    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic [WIDTH-1:0] shift;
    logic [WIDTH-1:0] shift_adv;
    logic [CW-1:0]    bit_cnt;
    logic [GW-1:0]    gap_cnt;
    logic             cur_bit;
    logic             dout_q;
    logic             busy_q;
    logic             done_q;
    logic             dout_nxt;
    logic             busy_nxt;
    logic             done_nxt;
    logic             last_bit;

    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            assign cur_bit   = shift[WIDTH-1];
            assign shift_adv = shift << 1;
        end else begin : g_lsb_first
            assign cur_bit   = shift[0];
            assign shift_adv = shift >> 1;
        end
    endgenerate

    assign last_bit = (bit_cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            dout_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            dout_q <= dout_nxt;
            busy_q <= busy_nxt;
            done_q <= done_nxt;
        end
    end

    // Any unreachable encoding falls back to IDLE, which also forces the line low.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (load) state_nxt = S_SYNC;
            S_SYNC: state_nxt = S_FILL;
            S_FILL: state_nxt = S_DATA;
            S_DATA: begin
                if (last_bit)     state_nxt = S_IDLE;
                else if (GAP > 0) state_nxt = S_GAP;
                else              state_nxt = S_SYNC;
            end
            S_GAP:  if (gap_cnt == '0) state_nxt = S_SYNC;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs are registered alongside the state, so they are derived from state_nxt.
    always_comb begin
        dout_nxt = 1'b0;
        case (state_nxt)
            S_SYNC:  dout_nxt = 1'b1;
            S_DATA:  dout_nxt = cur_bit;
            default: dout_nxt = 1'b0;
        endcase
        busy_nxt = (state_nxt != S_IDLE);
        done_nxt = (state == S_DATA) && last_bit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift   <= '0;
            bit_cnt <= '0;
            gap_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (load) begin
                        shift   <= data;
                        bit_cnt <= C_LAST_BIT;
                    end
                end
                S_DATA: begin
                    shift   <= shift_adv;
                    bit_cnt <= bit_cnt - 1'b1;
                    gap_cnt <= C_GAP_LOAD;
                end
                S_GAP: begin
                    if (gap_cnt != '0) gap_cnt <= gap_cnt - 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign dout = dout_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

`default_nettype wire

// File: tb/tb_fsml_frame_tx.sv
// Bench for fsml_frame_tx: three configurations driven in parallel, a frame-level
// reference model filling per-instance expectation queues, and a 1-x-b detector.
`default_nettype none

module tb_fsml_frame_tx;

    typedef struct packed {
        logic dout;
        logic busy;
        logic done;
        logic det;
    } ent_t;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       load  = 1'b0;
    logic [7:0] data  = 8'h00;
    logic [2:0] dout_v;
    logic [2:0] busy_v;
    logic [2:0] done_v;

    int W [3] = '{8, 8, 1};
    int G [3] = '{0, 2, 1};
    int M [3] = '{1, 0, 1};

    ent_t fut  [3][$];
    ent_t expq [3][$];

    int vectors = 0;
    int errors  = 0;
    int ds      = 0;

    fsml_frame_tx #(.WIDTH(8), .GAP(0), .MSB_FIRST(1)) u_a (
        .clk(clk), .rst_n(rst_n), .load(load), .data(data),
        .dout(dout_v[0]), .busy(busy_v[0]), .done(done_v[0])
    );

    fsml_frame_tx #(.WIDTH(8), .GAP(2), .MSB_FIRST(0)) u_b (
        .clk(clk), .rst_n(rst_n), .load(load), .data(data),
        .dout(dout_v[1]), .busy(busy_v[1]), .done(done_v[1])
    );

    fsml_frame_tx #(.WIDTH(1), .GAP(1), .MSB_FIRST(1)) u_c (
        .clk(clk), .rst_n(rst_n), .load(load), .data(data[0:0]),
        .dout(dout_v[2]), .busy(busy_v[2]), .done(done_v[2])
    );

    initial forever #5 clk = ~clk;

    // Expected cycle-by-cycle line for one word: frames of (1, 0, bit) with gaps,
    // Busy high throughout, then a single Done cycle with Busy low.
    task automatic push_word(input int i, input logic [7:0] d);
        ent_t e;
        logic bt;
        for (int b = 0; b < W[i]; b++) begin
            bt = (M[i] != 0) ? d[W[i]-1-b] : d[b];
            e = '{dout: 1'b1, busy: 1'b1, done: 1'b0, det: 1'b0}; fut[i].push_back(e);
            e = '{dout: 1'b0, busy: 1'b1, done: 1'b0, det: 1'b0}; fut[i].push_back(e);
            e = '{dout: bt,   busy: 1'b1, done: 1'b0, det: bt};   fut[i].push_back(e);
            if (b < W[i] - 1) begin
                for (int g = 0; g < G[i]; g++) begin
                    e = '{dout: 1'b0, busy: 1'b1, done: 1'b0, det: 1'b0};
                    fut[i].push_back(e);
                end
            end
        end
        e = '{dout: 1'b0, busy: 1'b0, done: 1'b1, det: 1'b0};
        fut[i].push_back(e);
    endtask

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) begin
                fut[i].delete();
                expq[i].push_back('0);
            end else begin
                if (fut[i].size() == 0 && load) push_word(i, data);
                if (fut[i].size() == 0) expq[i].push_back('0);
                else                    expq[i].push_back(fut[i].pop_front());
            end
        end
    end

    // Monitor: one comparison per instance per cycle, plus the detector on instance A.
    always @(negedge clk) begin
        ent_t e;
        logic pulse;
        for (int i = 0; i < 3; i++) begin
            if (expq[i].size() > 0) begin
                e = expq[i].pop_front();
                vectors++;
                if ({dout_v[i], busy_v[i], done_v[i]} !== {e.dout, e.busy, e.done}) begin
                    errors++;
                    $display("FAIL line inst%0d t=%0t got dout/busy/done=%b%b%b expected %b%b%b",
                             i, $time, dout_v[i], busy_v[i], done_v[i], e.dout, e.busy, e.done);
                end
                if (i == 0) begin
                    pulse = (ds == 2) && dout_v[0];
                    vectors++;
                    if (pulse !== e.det) begin
                        errors++;
                        $display("FAIL detector t=%0t got %b expected %b", $time, pulse, e.det);
                    end
                    if (!rst_n)          ds = 0;
                    else if (ds == 0)    ds = dout_v[0] ? 1 : 0;
                    else if (ds == 1)    ds = 2;
                    else                 ds = 0;
                end
            end
        end
    end

    task automatic chk_zero(input string name);
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if ({dout_v[i], busy_v[i], done_v[i]} !== 3'b000) begin
                errors++;
                $display("FAIL %s inst%0d got dout/busy/done=%b%b%b expected 000",
                         name, i, dout_v[i], busy_v[i], done_v[i]);
            end
        end
    endtask

    // Called right after a negedge: asserts reset between clock edges and checks
    // that all outputs fall without any clock edge.
    task automatic async_reset(input int hold);
        #1;
        rst_n = 1'b0;
        load  = 1'b0;
        #1;
        chk_zero("async_reset");
        for (int i = 0; i < 3; i++) fut[i].delete();
        ds = 0;
        repeat (hold) @(negedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic idle(input int n);
        load = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        // Reset with Load held high: outputs must stay low.
        load = 1'b1;
        data = 8'hA5;
        repeat (3) @(negedge clk);
        chk_zero("reset_hold");
        rst_n = 1'b1;
        @(negedge clk);
        load = 1'b0;
        idle(30);

        // Load pulse in the middle of a word must be ignored.
        data = 8'h00; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        idle(5);
        data = 8'hFF; load = 1'b1;
        @(negedge clk);
        data = 8'h5A; load = 1'b0;
        idle(50);

        // LSB-first gapped word.
        data = 8'h01; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        idle(45);

        // Load held high across two words.
        data = 8'h3C; load = 1'b1;
        repeat (52) @(negedge clk);
        idle(45);

        // Reset asserted inside the third frame.
        data = 8'hC3; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (7) @(negedge clk);
        async_reset(2);
        idle(12);

        // Randomized traffic with occasional mid-word resets.
        for (int n = 0; n < 1500; n++) begin
            @(negedge clk);
            if ($urandom_range(0, 299) == 0) begin
                async_reset($urandom_range(1, 3));
            end else begin
                load = ($urandom_range(0, 3) == 0);
                data = 8'($urandom);
            end
        end
        idle(60);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

`default_nettype wire
